registers_dump: RTL and testbench

Debug-side reader of the register bank's flattened debug bus (`o_bus_debug`). On a start request it snapshots all registers in one cycle, then streams them out as bytes over a valid/ready handshake toward the debug UART transmitter. Sits between the ID-stage register bank and the debug unit's TX path, so the host can read the full architectural register state while the pipeline is halted or running.

---
 rtl/registers_dump_pkg.sv | 23 ++
 rtl/registers_dump_if.sv | 11 +
 rtl/registers_dump_word_byte_mux.sv | 21 ++
 rtl/registers_dump.sv | 86 ++++++++
 tb/tb_registers_dump.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/registers_dump_pkg.sv
// Shared constants and types for the register-bank debug dumper.
// Defaults match the 32 x 32-bit architectural register bank.
package registers_dump_pkg;

   localparam int RD_DEFAULT_BANK_SIZE = 32;
   localparam int RD_DEFAULT_REG_SIZE  = 32;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_SEND = 2'd1;
   localparam state_t ST_DONE = 2'd2;

   // Counter width that never collapses to zero bits for single-entry ranges.
   function automatic int idx_width(input int n);
      if (n <= 1) begin
         return 1;
      end else begin
         return $clog2(n);
      end
   endfunction

endpackage

// File: rtl/registers_dump_if.sv
// Byte stream from the dumper toward the debug UART transmitter.
interface registers_dump_if;
   logic [7:0] o_data;
   logic       o_valid;
   logic       i_ready;
   logic       o_busy;
   logic       o_done;

   modport master (output o_data, output o_valid, output o_busy, output o_done, input i_ready);
   modport slave  (input o_data, input o_valid, input o_busy, input o_done, output i_ready);
endinterface

// File: rtl/registers_dump_word_byte_mux.sv
// Picks one byte out of a register word, byte index 0 being the most significant byte.
module word_byte_mux #(
   parameter int WORD_W = 32,
   parameter int IDX_W  = 2
) (
   input  logic [WORD_W-1:0] i_word,
   input  logic [IDX_W-1:0]  i_byte_idx,
   output logic [7:0]        o_byte
);

   localparam int BYTES = WORD_W / 8;

   // One-hot OR of the candidate bytes; exactly one index matches.
   always_comb begin
      o_byte = 8'h00;
      for (int k = 0; k < BYTES; k++) begin
         o_byte = o_byte | (i_word[WORD_W-1-8*k -: 8] & {8{i_byte_idx == IDX_W'(k)}});
      end
   end

endmodule

// File: rtl/registers_dump.sv
// Snapshots the flattened register bank on request and streams it out MSB-first,
// register 0 first, over a valid/ready byte handshake.
module registers_dump
   import registers_dump_pkg::*;
#(
   parameter int REGISTERS_BANK_SIZE = RD_DEFAULT_BANK_SIZE,
   parameter int REGISTERS_SIZE      = RD_DEFAULT_REG_SIZE
) (
   input  logic                                          i_clk,
   input  logic                                          i_reset,
   input  logic                                          i_start,
   input  logic [REGISTERS_BANK_SIZE*REGISTERS_SIZE-1:0] i_bus_debug,
   registers_dump_if.master                              tx
);

   localparam int BYTES_PER_REG = REGISTERS_SIZE / 8;
   localparam int REG_IDX_W     = idx_width(REGISTERS_BANK_SIZE);
   localparam int BYTE_IDX_W    = idx_width(BYTES_PER_REG);
   localparam logic [REG_IDX_W-1:0]  LAST_REG  = REG_IDX_W'(REGISTERS_BANK_SIZE - 1);
   localparam logic [BYTE_IDX_W-1:0] LAST_BYTE = BYTE_IDX_W'(BYTES_PER_REG - 1);

   state_t                                        r_state;
   logic [REG_IDX_W-1:0]                          r_reg_idx;
   logic [BYTE_IDX_W-1:0]                         r_byte_idx;
   logic [REGISTERS_BANK_SIZE*REGISTERS_SIZE-1:0] r_snapshot;

   logic                      w_accept;
   logic                      w_last;
   logic [REGISTERS_SIZE-1:0] w_word;
   logic [7:0]                w_byte;

   assign w_accept = (r_state == ST_SEND) && tx.i_ready;
   assign w_last   = (r_reg_idx == LAST_REG) && (r_byte_idx == LAST_BYTE);
   assign w_word   = r_snapshot[int'(r_reg_idx)*REGISTERS_SIZE +: REGISTERS_SIZE];

   // Dump sequencer: capture on start, walk bytes on each accepted transfer.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state    <= ST_IDLE;
         r_reg_idx  <= '0;
         r_byte_idx <= '0;
         r_snapshot <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_state    <= ST_SEND;
                  r_snapshot <= i_bus_debug;
                  r_reg_idx  <= '0;
                  r_byte_idx <= '0;
               end
            end
            ST_SEND: begin
               if (w_accept) begin
                  if (w_last) begin
                     r_state <= ST_DONE;
                  end else if (r_byte_idx == LAST_BYTE) begin
                     r_byte_idx <= '0;
                     r_reg_idx  <= r_reg_idx + REG_IDX_W'(1);
                  end else begin
                     r_byte_idx <= r_byte_idx + BYTE_IDX_W'(1);
                  end
               end
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   word_byte_mux #(
      .WORD_W (REGISTERS_SIZE),
      .IDX_W  (BYTE_IDX_W)
   ) u_byte_mux (
      .i_word     (w_word),
      .i_byte_idx (r_byte_idx),
      .o_byte     (w_byte)
   );

   // Handshake flags come straight from the state register; data from the snapshot.
   assign tx.o_data  = w_byte;
   assign tx.o_valid = (r_state == ST_SEND);
   assign tx.o_busy  = (r_state == ST_SEND);
   assign tx.o_done  = (r_state == ST_DONE);

endmodule

// File: tb/tb_registers_dump.sv
// Scoreboard bench: stimulus queues expected bytes/done cycles, negedge monitors check them.
module tb_registers_dump;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         start2;
   logic [1023:0] bus;
   logic [63:0]  bus2;

   registers_dump_if if1 ();
   registers_dump_if if2 ();

   registers_dump dut (
      .i_clk(clk), .i_reset(rst), .i_start(start), .i_bus_debug(bus), .tx(if1)
   );

   registers_dump #(.REGISTERS_BANK_SIZE(4), .REGISTERS_SIZE(16)) dut2 (
      .i_clk(clk), .i_reset(rst), .i_start(start2), .i_bus_debug(bus2), .tx(if2)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_q[$];
   int         done_q[$];
   logic [7:0] exp2_q[$];
   int         done2_q[$];
   int         accepted = 0;
   bit         rand_ready = 1'b0;
   bit         hold_pend = 1'b0;
   logic [7:0] hold_data;
   logic [31:0] regs[32];

   task automatic check(input string name, input int act, input int expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   // Main DUT monitor: pop an expected byte on every transfer, check stalls and done.
   always @(negedge clk) begin
      if (if1.o_valid && if1.i_ready) begin
         accepted++;
         if (exp_q.size() == 0) fail_now("extra_byte");
         else check("byte", int'(if1.o_data), int'(exp_q.pop_front()));
      end
      if (hold_pend && if1.o_valid) check("stall_hold", int'(if1.o_data), int'(hold_data));
      hold_pend = if1.o_valid && !if1.i_ready;
      hold_data = if1.o_data;
      if (if1.o_done) begin
         if (done_q.size() == 0) begin
            fail_now("spurious_done");
         end else begin
            int e;
            e = done_q.pop_front();
            check("done_busy", int'(if1.o_busy), 0);
            check("bytes_left_at_done", exp_q.size() - 128 * done_q.size(), 0);
            if (e >= 0) check("done_cycle", cyc, e);
         end
      end
   end

   // Narrow-parameter DUT monitor.
   always @(negedge clk) begin
      if (if2.o_valid && if2.i_ready) begin
         if (exp2_q.size() == 0) fail_now("v2_extra_byte");
         else check("v2_byte", int'(if2.o_data), int'(exp2_q.pop_front()));
      end
      if (if2.o_done) begin
         if (done2_q.size() == 0) fail_now("v2_spurious_done");
         else begin
            check("v2_done_cycle", cyc, done2_q.pop_front());
            check("v2_bytes_left", exp2_q.size(), 0);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if1.i_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   endtask

   task automatic apply_bus();
      for (int j = 0; j < 32; j++) bus[j*32 +: 32] = regs[j];
   endtask

   // Reference order: register 0 first, most significant byte first.
   task automatic push_dump();
      for (int j = 0; j < 32; j++)
         for (int k = 0; k < 4; k++)
            exp_q.push_back(8'((regs[j] >> (8 * (3 - k))) & 32'hFF));
   endtask

   task automatic wait_idle(input int limit);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || done_q.size() != 0) && n < limit) begin
         tick();
         n++;
      end
      if (n >= limit) begin
         fail_now("timeout_waiting_for_dump");
         exp_q.delete();
         done_q.delete();
      end
      tick();
      tick();
   endtask

   task automatic run_dump(input bit timed);
      push_dump();
      done_q.push_back(timed ? cyc + 129 : -1);
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_idle(2000);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      start = 1'b0;
      start2 = 1'b0;
      bus = '0;
      bus2 = '0;
      if1.i_ready = 1'b1;
      if2.i_ready = 1'b1;
      repeat (3) tick();
      check("rst_valid", int'(if1.o_valid), 0);
      check("rst_busy", int'(if1.o_busy), 0);
      check("rst_done", int'(if1.o_done), 0);
      check("rst_data", int'(if1.o_data), 0);
      rst = 1'b0;
      tick();

      // Basic dump with the recognisable pattern
      for (int j = 0; j < 32; j++) regs[j] = 32'h01020300 + 32'(j);
      apply_bus();
      run_dump(1'b1);

      // Backpressure with random register contents
      for (int j = 0; j < 32; j++) regs[j] = $urandom;
      apply_bus();
      rand_ready = 1'b1;
      run_dump(1'b0);
      rand_ready = 1'b0;
      tick();

      // Snapshot isolation: register 5 changes after the start edge
      for (int j = 0; j < 32; j++) regs[j] = $urandom;
      regs[5] = 32'hDEADBEEF;
      apply_bus();
      push_dump();
      done_q.push_back(cyc + 129);
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (10) tick();
      bus[5*32 +: 32] = 32'h12345678;
      wait_idle(2000);

      // Start held high: one dump, then a new one right after DONE
      for (int j = 0; j < 32; j++) regs[j] = 32'h01020300 + 32'(j);
      apply_bus();
      push_dump();
      push_dump();
      done_q.push_back(cyc + 129);
      done_q.push_back(cyc + 259);
      start = 1'b1;
      repeat (140) tick();
      start = 1'b0;
      wait_idle(2000);
      repeat (3) tick();
      check("no_third_dump", int'(if1.o_busy), 0);

      // Reset mid-dump after byte 40
      push_dump();
      done_q.push_back(-1);
      accepted = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int n = 0; n < 500 && accepted < 40; n++) tick();
      check("reached_byte_40", int'(accepted >= 40), 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_valid", int'(if1.o_valid), 0);
      check("midrst_busy", int'(if1.o_busy), 0);
      check("midrst_done", int'(if1.o_done), 0);
      check("midrst_data", int'(if1.o_data), 0);
      exp_q.delete();
      done_q.delete();
      repeat (5) tick();
      check("idle_after_rst", int'(if1.o_valid), 0);
      run_dump(1'b1);

      // Reset wins over a simultaneous start
      rst = 1'b1;
      start = 1'b1;
      tick();
      rst = 1'b0;
      start = 1'b0;
      check("rst_beats_start", int'(if1.o_busy), 0);
      tick();
      check("rst_beats_start_later", int'(if1.o_busy), 0);

      // Narrow variant: 4 x 16-bit registers
      bus2 = {16'h0718, 16'hE5F6, 16'hC3D4, 16'hA1B2};
      begin
         logic [15:0] r2[4];
         r2 = '{16'hA1B2, 16'hC3D4, 16'hE5F6, 16'h0718};
         for (int j = 0; j < 4; j++) begin
            exp2_q.push_back(r2[j][15:8]);
            exp2_q.push_back(r2[j][7:0]);
         end
      end
      done2_q.push_back(cyc + 9);
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      for (int n = 0; n < 100 && (exp2_q.size() != 0 || done2_q.size() != 0); n++) tick();
      check("v2_complete", exp2_q.size() + done2_q.size(), 0);
      repeat (3) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
